// File: rtl/life_gen_engine.sv
// life_gen_engine: 8x8 Game-of-Life generation engine for the VGA board renderer.
// Two flop banks: the renderer reads the display bank while the next
// generation is built cell-serially in the work bank; a one-cycle SWAP
// flips the bank select, so the renderer never sees a half-updated board.
//
// Pulse semantics: frame_tick, step_req and reseed are single-cycle pulses
// sampled on the rising clock edge; there is no back-pressure. A trigger
// (step_req or a due frame step) is accepted only in IDLE. A trigger that
// arrives while busy is dropped and latches overrun. A trigger that
// coincides with wr_en in IDLE is held for one cycle so the write lands first.
module life_gen_engine #(
  parameter int WIDTH_BITS     = 3,
  parameter int HEIGHT_BITS    = 3,
  parameter int FRAMES_PER_GEN = 60,
  parameter logic [(2**(WIDTH_BITS+HEIGHT_BITS))-1:0] SEED = 64'h0A30_1548_1148_1148
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              frame_tick,
  input  logic                              run,
  input  logic                              step_req,
  input  logic                              reseed,
  input  logic                              wr_en,
  input  logic [WIDTH_BITS+HEIGHT_BITS-1:0] wr_addr,
  input  logic                              wr_data,
  input  logic [WIDTH_BITS+HEIGHT_BITS-1:0] rd_addr,
  output logic                              rd_cell,
  output logic                              busy,
  output logic [15:0]                       gen_count,
  output logic                              overrun
);

  localparam int BOARD_WIDTH  = 2**WIDTH_BITS;
  localparam int BOARD_HEIGHT = 2**HEIGHT_BITS;
  localparam int SIZE         = BOARD_WIDTH * BOARD_HEIGHT;
  localparam int AW           = WIDTH_BITS + HEIGHT_BITS;
  localparam int FCW          = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_SWAP = 2'd2
  } state_t;

  state_t            state;
  logic [AW-1:0]     idx;
  logic              sel;
  logic              pend;
  logic [SIZE-1:0]   bank0;
  logic [SIZE-1:0]   bank1;
  logic [SIZE-1:0]   display;
  logic [FCW-1:0]    frame_cnt;
  logic              step_due;
  logic              trigger;
  logic [HEIGHT_BITS-1:0] scan_row;
  logic [WIDTH_BITS-1:0]  scan_col;
  logic [3:0]        nbr_count;
  logic              next_alive;

  // Display bank selection and the renderer read port.
  always_comb begin
    display = sel ? bank1 : bank0;
    rd_cell = display[rd_addr];
  end

  assign scan_row = idx[AW-1:WIDTH_BITS];
  assign scan_col = idx[WIDTH_BITS-1:0];

  assign step_due = frame_tick && run && (frame_cnt == FCW'(FRAMES_PER_GEN - 1));
  assign trigger  = step_due || step_req;
  assign busy     = (state != S_IDLE);

  // Frame pacing: counts ticks while running; the terminal tick raises step_due.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_tick && run) begin
      frame_cnt <= step_due ? '0 : frame_cnt + 1'b1;
    end
  end

  // Neighbour count of the scanned cell; off-board positions are dead (no wrap).
  always_comb begin
    nbr_count = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int r;
        int c;
        r = int'(scan_row) + dr;
        c = int'(scan_col) + dc;
        if (!(dr == 0 && dc == 0) && r >= 0 && r < BOARD_HEIGHT &&
            c >= 0 && c < BOARD_WIDTH) begin
          nbr_count = nbr_count + {3'b000, display[AW'(r * BOARD_WIDTH + c)]};
        end
      end
    end
    next_alive = (nbr_count == 4'd3) || (display[idx] && (nbr_count == 4'd2));
  end

  // Engine FSM with bank storage: reseed > wr_en > trigger; SCAN fills the
  // work bank, SWAP publishes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      sel       <= 1'b0;
      pend      <= 1'b0;
      bank0     <= SEED;
      bank1     <= '0;
      gen_count <= '0;
      overrun   <= 1'b0;
    end else if (reseed) begin
      state   <= S_IDLE;
      idx     <= '0;
      pend    <= 1'b0;
      overrun <= 1'b0;
      if (sel) bank1 <= SEED;
      else     bank0 <= SEED;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_en) begin
            if (sel) bank1[wr_addr] <= wr_data;
            else     bank0[wr_addr] <= wr_data;
            if (trigger) pend <= 1'b1;
          end else if (trigger || pend) begin
            pend  <= 1'b0;
            idx   <= '0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (trigger) overrun <= 1'b1;
          if (sel) bank0[idx] <= next_alive;
          else     bank1[idx] <= next_alive;
          if (idx == AW'(SIZE - 1)) state <= S_SWAP;
          idx <= idx + 1'b1;
        end
        S_SWAP: begin
          if (trigger) overrun <= 1'b1;
          sel       <= ~sel;
          gen_count <= gen_count + 16'd1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_gen_engine.sv
// tb_life_gen_engine: reference-model bench for life_gen_engine.
// A board-level model computes each generation from the Life rules and
// applies it after the scan latency; a compare process checks all outputs
// every cycle, and directed sequences pin the model with literal boards.
`timescale 1ns/1ps
module tb_life_gen_engine;

  localparam int FPG = 60;
  localparam logic [63:0] SEED_V = 64'h0A30_1548_1148_1148;
  localparam int SCAN_LEN = 65;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        run = 1'b0;
  logic        step_req = 1'b0;
  logic        reseed = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic        wr_data = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic        rd_cell;
  logic        busy;
  logic [15:0] gen_count;
  logic        overrun;

  int total = 0;
  int bad = 0;

  life_gen_engine #(
    .WIDTH_BITS(3),
    .HEIGHT_BITS(3),
    .FRAMES_PER_GEN(FPG),
    .SEED(SEED_V)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .run(run),
    .step_req(step_req),
    .reseed(reseed),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_cell(rd_cell),
    .busy(busy),
    .gen_count(gen_count),
    .overrun(overrun)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] m_board = SEED_V;
  logic [63:0] m_next = '0;
  logic [15:0] m_gen = '0;
  int          m_left = 0;
  int          m_fcnt = 0;
  bit          m_pend = 0;
  bit          m_ovr = 0;
  bit          m_started = 0;
  bit          m_due;
  bit          m_trig;

  function automatic bit cell_at(input int r, input int c);
    if (r < 0 || r > 7 || c < 0 || c > 7) return 1'b0;
    return m_board[6'(r * 8 + c)];
  endfunction

  function automatic logic [63:0] life_of_board();
    logic [63:0] nb;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n;
        n = cell_at(r - 1, c - 1) + cell_at(r - 1, c) + cell_at(r - 1, c + 1)
          + cell_at(r, c - 1) + cell_at(r, c + 1)
          + cell_at(r + 1, c - 1) + cell_at(r + 1, c) + cell_at(r + 1, c + 1);
        nb[6'(r * 8 + c)] = (n == 3) || (cell_at(r, c) && n == 2);
      end
    end
    return nb;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_board = SEED_V;
      m_gen   = '0;
      m_left  = 0;
      m_fcnt  = 0;
      m_pend  = 0;
      m_ovr   = 0;
    end else begin
      m_due = frame_tick && run && (m_fcnt == FPG - 1);
      if (frame_tick && run) m_fcnt = m_due ? 0 : m_fcnt + 1;
      m_trig = m_due || step_req;
      if (reseed) begin
        m_board = SEED_V;
        m_left  = 0;
        m_pend  = 0;
        m_ovr   = 0;
      end else if (m_left > 0) begin
        if (m_trig) m_ovr = 1;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_board = m_next;
          m_gen   = m_gen + 16'd1;
        end
      end else if (wr_en) begin
        m_board[wr_addr] = wr_data;
        if (m_trig) m_pend = 1;
      end else if (m_trig || m_pend) begin
        m_pend = 0;
        m_next = life_of_board();
        m_left = SCAN_LEN;
      end
    end
    m_started = 1;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("gen_count", 64'(gen_count), 64'(m_gen));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      chk("rd_cell", 64'(rd_cell), 64'(m_board[rd_addr]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
    wr_en = 1'b0;
    step_req = 1'b0;
    reseed = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic write_cell(input int a, input bit d);
    cyc();
    wr_en = 1'b1;
    wr_addr = 6'(a);
    wr_data = d;
  endtask

  task automatic pulse_step();
    cyc();
    step_req = 1'b1;
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) write_cell(i, 1'b0);
  endtask

  task automatic step_and_wait();
    pulse_step();
    idle(70);
  endtask

  task automatic expect_board(input string name, input logic [63:0] mask);
    for (int i = 0; i < 64; i++) begin
      cyc();
      rd_addr = 6'(i);
      #1;
      chk(name, 64'(rd_cell), 64'(mask[i]));
    end
  endtask

  function automatic logic [63:0] cells(input int a, input int b, input int c, input int d);
    logic [63:0] m;
    m = '0;
    if (a >= 0) m[6'(a)] = 1'b1;
    if (b >= 0) m[6'(b)] = 1'b1;
    if (c >= 0) m[6'(c)] = 1'b1;
    if (d >= 0) m[6'(d)] = 1'b1;
    return m;
  endfunction

  // ---------------- stimulus ----------------
  logic [63:0] seed_mask;

  initial begin
    seed_mask = '0;
    foreach (seed_mask[i]) seed_mask[i] = 1'b0;
    seed_mask = cells(3, 6, 8, 12) | cells(19, 22, 24, 28) | cells(35, 38, 40, 42)
              | cells(44, 52, 53, 57) | cells(59, -1, -1, -1);

    // reset
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_gen", 64'(gen_count), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    expect_board("reset_seed", seed_mask);

    // blinker, with the exact busy window
    clear_board();
    write_cell(27, 1'b1);
    write_cell(28, 1'b1);
    write_cell(29, 1'b1);
    pulse_step();                 // cycle T
    cyc(); #1;                    // T+1
    chk("blink_busy_first", 64'(busy), 64'd1);
    idle(64); #1;                 // T+65
    chk("blink_busy_last", 64'(busy), 64'd1);
    cyc(); #1;                    // T+66
    chk("blink_busy_done", 64'(busy), 64'd0);
    chk("blink_gen1", 64'(gen_count), 64'd1);
    expect_board("blink_vertical", cells(20, 28, 36, -1));
    step_and_wait();
    expect_board("blink_horizontal", cells(27, 28, 29, -1));
    chk("blink_gen2", 64'(gen_count), 64'd2);

    // edges do not wrap
    clear_board();
    write_cell(7, 1'b1);
    write_cell(8, 1'b1);
    write_cell(15, 1'b1);
    step_and_wait();
    expect_board("edge_empty", 64'd0);
    write_cell(0, 1'b1);
    write_cell(1, 1'b1);
    write_cell(8, 1'b1);
    write_cell(9, 1'b1);
    repeat (3) step_and_wait();
    expect_board("corner_block", cells(0, 1, 8, 9));
    chk("corner_gen", 64'(gen_count), 64'd6);

    // overrun and write guard during SCAN
    pulse_step();
    idle(9);
    pulse_step();
    idle(4);
    write_cell(63, 1'b1);
    idle(70);
    chk("ovr_set", 64'(overrun), 64'd1);
    chk("ovr_gen", 64'(gen_count), 64'd7);
    expect_board("ovr_board", cells(0, 1, 8, 9));

    // reseed mid-scan
    pulse_step();
    idle(30);
    cyc();
    reseed = 1'b1;
    cyc(); #1;
    chk("reseed_busy", 64'(busy), 64'd0);
    chk("reseed_ovr", 64'(overrun), 64'd0);
    chk("reseed_gen", 64'(gen_count), 64'd7);
    expect_board("reseed_board", seed_mask);

    // frame-paced stepping
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 180; i++) begin
      cyc();
      frame_tick = 1'b1;
      idle(2);
    end
    idle(70); #1;
    chk("frames_gen3", 64'(gen_count), 64'd3);
    run = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      frame_tick = 1'b1;
      idle(2);
    end
    idle(70); #1;
    chk("frames_hold", 64'(gen_count), 64'd3);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if ($urandom_range(0, 199) == 0) run = ~run;
      frame_tick = ($urandom_range(0, 2) == 0);
      step_req   = ($urandom_range(0, 49) == 0);
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_addr    = 6'($urandom_range(0, 63));
      wr_data    = 1'($urandom_range(0, 1));
      reseed     = ($urandom_range(0, 499) == 0);
      reset      = ($urandom_range(0, 1499) == 0);
      rd_addr    = 6'($urandom_range(0, 63));
    end
    cyc();
    reset = 1'b0;
    idle(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // time limit
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
